// File: rtl/fetch_ctrl.sv
// Fetch controller: issues one instruction-memory read at the current PC, waits for the
// response, then presents the instruction to decode under valid/ready. It also drives the
// PC register's write port for sequential advance, redirects and halt.
module fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] curr_pc,
  output logic [15:0] pc_new,
  output logic        pc_write,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_plus2,
  input  logic        if_ready,
  output logic        halted
);

  typedef enum logic [1:0] {StFetch, StWait, StHold, StHalted} state_e;

  state_e      state_q;
  logic        flush_q;   // response of the outstanding request must be dropped
  logic [15:0] pc_plus2;
  logic        redirect_act;
  logic        seq_write;

  assign pc_plus2     = curr_pc + 16'd2;
  assign redirect_act = redirect_valid && (state_q != StHalted);
  // A halt in the response cycle discards the data, so no sequential advance then.
  assign seq_write    = (state_q == StWait) && imem_done && !flush_q && !halt;

  // Request and PC-write outputs; redirect outranks the sequential +2 write.
  always_comb begin
    imem_req  = 1'b0;
    pc_write  = 1'b0;
    pc_new    = 16'h0000;
    imem_addr = curr_pc;
    if (rst) begin
      imem_req = (state_q == StFetch);
      if (redirect_act) begin
        pc_write = 1'b1;
        pc_new   = redirect_pc;
      end else if (seq_write) begin
        pc_write = 1'b1;
        pc_new   = pc_plus2;
      end
    end
  end

  // Fetch FSM with registered decode-side outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StFetch;
      flush_q     <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= 16'h0000;
      if_pc_plus2 <= 16'h0000;
      halted      <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (redirect_valid) begin
            // The request just issued targets the old PC; its response is stale.
            state_q <= StWait;
            flush_q <= 1'b1;
          end else if (halt) begin
            state_q <= StHalted;
            halted  <= 1'b1;
          end else begin
            state_q <= StWait;
            flush_q <= 1'b0;
          end
        end
        StWait: begin
          if (redirect_valid) begin
            if (imem_done) begin
              state_q <= StFetch;
              flush_q <= 1'b0;
            end else begin
              flush_q <= 1'b1;
            end
          end else if (halt) begin
            state_q <= StHalted;
            flush_q <= 1'b0;
            halted  <= 1'b1;
          end else if (imem_done) begin
            flush_q <= 1'b0;
            if (flush_q) begin
              state_q <= StFetch;
            end else begin
              state_q     <= StHold;
              if_valid    <= 1'b1;
              if_instr    <= imem_rdata;
              if_pc_plus2 <= pc_plus2;
            end
          end
        end
        StHold: begin
          if (redirect_valid) begin
            state_q  <= StFetch;
            if_valid <= 1'b0;
          end else if (halt) begin
            state_q  <= StHalted;
            if_valid <= 1'b0;
            halted   <= 1'b1;
          end else if (if_ready) begin
            state_q  <= StFetch;
            if_valid <= 1'b0;
          end
        end
        StHalted: begin
          state_q <= StHalted;
        end
        default: begin
          state_q <= StFetch;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch controller sitting directly upstream of the PC register. It reads the stored PC and issues an instruction-memory request at that address. It waits out a multicycle memory response, then hands the instruction and PC+2 to decode under a valid/ready handshake. It drives the PC register's new-value and write-enable inputs for sequential advance, for redirects from later stages, and for halt.

## Interface
Parameters:
- none. All datapaths are fixed at 16 bits; instructions are 16-bit and PC increment is +2.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset.
- curr_pc  in  16  PC value currently held by the PC register.
- pc_new  out  16  next PC, to the PC register's New_PC input.
- pc_write  out  1  PC register write enable, to its Write input.
- imem_req  out  1  one-cycle read request pulse.
- imem_addr  out  16  read address; equals curr_pc while imem_req=1.
- imem_done  in  1  response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  in  16  instruction word.
- redirect_valid  in  1  taken branch/jump from a later stage.
- redirect_pc  in  16  redirect target.
- halt  in  1  decode has seen a HALT instruction.
- if_valid  out  1  fetched instruction available to decode.
- if_instr  out  16  fetched instruction.
- if_pc_plus2  out  16  PC of the fetched instruction + 2.
- if_ready  in  1  decode accepts the instruction this cycle.
- halted  out  1  fetch permanently stopped.

## Operation
- States: FETCH, WAIT, HOLD, HALTED. Reset state is FETCH.
- FETCH:
  - imem_req=1, imem_addr=curr_pc.
  - Next state is WAIT.
- WAIT:
  - imem_req=0.
  - On imem_done with no flush pending:
    - capture imem_rdata into if_instr and curr_pc+2 into if_pc_plus2;
    - pc_write=1, pc_new=curr_pc+2;
    - next state is HOLD.
  - On imem_done with flush pending: discard the data, clear flush, next state is FETCH, no PC write.
- HOLD:
  - if_valid=1.
  - if_ready=1 completes the transfer; next state is FETCH.
  - if_instr and if_pc_plus2 stay stable while if_valid=1 and if_ready=0.
- Redirect (any state except HALTED):
  - pc_write=1, pc_new=redirect_pc, in the same cycle.
  - Redirect has priority over the sequential +2 write.
  - FETCH: the request issued this cycle is treated as stale; go to WAIT with flush set.
  - WAIT without imem_done: set flush.
  - WAIT with imem_done: discard the data, next state is FETCH.
  - HOLD: drop if_valid the next cycle (no transfer even if if_ready=1), next state is FETCH.
- Halt:
  - halt=1 with redirect_valid=0 moves to HALTED next cycle; any in-flight response is discarded.
  - redirect_valid=1 and halt=1 in the same cycle: redirect wins and halt is ignored.
  - HALTED: imem_req=0, pc_write=0, if_valid=0, halted=1. Only reset exits.
- Arithmetic: curr_pc+2 is modulo 2^16, so 0xFFFE advances to 0x0000. Odd PCs are passed through unchanged.
- pc_new and pc_write are combinational from state, imem_done and redirect. The PC register updates on the edge ending that cycle.
- imem_done outside WAIT is ignored.

## Timing
- Reset (rst=0 at an edge):
  - state=FETCH, flush=0.
  - if_valid=0, if_instr=0x0000, if_pc_plus2=0x0000, halted=0.
  - While rst=0: imem_req=0, pc_write=0, pc_new=0x0000.
- First imem_req is in the first cycle with rst=1.
- Reset mid-WAIT: the pending response is abandoned, and a late imem_done after reset is ignored because the state is FETCH.
- Minimum latency: request in cycle N, imem_done in N+1, if_valid in N+2. With if_ready=1, the next request is in N+3 (3 cycles per instruction).
- Memory latency is 1 or more cycles and unbounded; WAIT holds indefinitely.
- curr_pc changes only on edges where pc_write=1.

## Test plan
- Reset then sequential fetch:
  - stimulus: curr_pc=0x0000, imem_done one cycle after each req, if_ready=1.
  - required: imem_addr sequence 0x0000, 0x0002, 0x0004; if_pc_plus2 of 0x0002, 0x0004, 0x0006; one instruction every 3 cycles.
- Memory stall:
  - stimulus: imem_done delayed 5 cycles.
  - required: imem_req pulses once, pc_write stays 0 for 5 cycles, if_valid rises the cycle after done.
- Decode backpressure:
  - stimulus: if_ready=0 for 4 cycles while in HOLD.
  - required: if_instr stable, no new imem_req, transfer on the first if_ready=1.
- Redirect in WAIT:
  - stimulus: redirect_valid with redirect_pc=0x1234 two cycles before imem_done.
  - required: pc_write same cycle with pc_new=0x1234, the response is discarded with no if_valid, next imem_addr=0x1234.
- Simultaneous redirect and halt, then halt alone:
  - stimulus: redirect to 0x0100 with halt=1, then a later halt=1.
  - required: PC written to 0x0100, no halt; then halted=1, with no imem_req or pc_write until rst=0.
- Wrap: curr_pc=0xFFFE fetch completes -> pc_new=0x0000, if_pc_plus2=0x0000.
